// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (CPU LSU) has priority, and port 1 (debug/DMA) is boosted
// after waiting too long. Performs sub-word lane steering, store byte enables and load extension.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [15:0] dmem_address,
  output logic [31:0] dmem_data,
  output logic [3:0]  dmem_wren,
  input  logic [31:0] dmem_q
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic        boost_r, boost_nxt_s;
  logic        p1_win_s, p0_gnt_s, p1_gnt_s;
  logic        sel_we_s, sel_unsigned_s, sel_err_s;
  logic [15:0] sel_addr_s;
  logic [31:0] sel_wdata_s, lane_data_s, resp_data_s;
  logic [1:0]  sel_size_s;
  logic [3:0]  lane_mask_s;
  logic        p0_rvalid_r, p1_rvalid_r, p0_err_r, p1_err_r;
  logic [31:0] p0_rdata_r, p1_rdata_r;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = lo[0];
      2'b10:   e = (lo != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lo;
      2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] q, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = q[{lo, 3'b000} +: 8];
    h = lo[1] ? q[31:16] : q[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = q;
    endcase
    return r;
  endfunction

  // Grant decision and port-1 starvation tracking; reset masks both grants.
  always_comb begin
    p1_win_s = p1_req && (boost_r || !p0_req);
    p0_gnt_s = i_reset && p0_req && !p1_win_s;
    p1_gnt_s = i_reset && p1_win_s;
    if (p1_req && !p1_gnt_s) begin
      wait_cnt_nxt_s = (wait_cnt_r == 4'hF) ? 4'hF : wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_nxt_s = 4'd0;
    end
    if (p1_gnt_s) begin
      boost_nxt_s = 1'b0;
    end else begin
      boost_nxt_s = boost_r || (wait_cnt_nxt_s >= MAX_WAIT_C);
    end
  end

  // Field mux of the granted port and memory-side lane steering.
  always_comb begin
    if (p1_gnt_s) begin
      sel_we_s       = p1_we;
      sel_addr_s     = p1_addr;
      sel_wdata_s    = p1_wdata;
      sel_size_s     = p1_size;
      sel_unsigned_s = p1_unsigned;
    end else begin
      sel_we_s       = p0_we;
      sel_addr_s     = p0_addr;
      sel_wdata_s    = p0_wdata;
      sel_size_s     = p0_size;
      sel_unsigned_s = p0_unsigned;
    end
    sel_err_s   = access_err(sel_size_s, sel_addr_s[1:0]);
    lane_mask_s = lane_mask(sel_size_s, sel_addr_s[1:0]);
    case (sel_size_s)
      2'b00:   lane_data_s = {4{sel_wdata_s[7:0]}};
      2'b01:   lane_data_s = {2{sel_wdata_s[15:0]}};
      default: lane_data_s = sel_wdata_s;
    endcase
    if (sel_we_s || sel_err_s) begin
      resp_data_s = 32'h0000_0000;
    end else begin
      resp_data_s = load_extract(dmem_q, sel_size_s, sel_addr_s[1:0], sel_unsigned_s);
    end
    if (p0_gnt_s || p1_gnt_s) begin
      dmem_address = {sel_addr_s[15:2], 2'b00};
      dmem_data    = lane_data_s;
      dmem_wren    = (sel_we_s && !sel_err_s) ? lane_mask_s : 4'b0000;
    end else begin
      dmem_address = 16'h0000;
      dmem_data    = 32'h0000_0000;
      dmem_wren    = 4'b0000;
    end
  end

  // Arbitration state: starvation counter and sticky boost flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wait_cnt_r <= 4'd0;
      boost_r    <= 1'b0;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
      boost_r    <= boost_nxt_s;
    end
  end

  // Response registers: one-cycle rvalid pulse per grant, data/err captured at the grant edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= 32'h0000_0000;
      p1_rdata_r  <= 32'h0000_0000;
      p0_err_r    <= 1'b0;
      p1_err_r    <= 1'b0;
    end else begin
      p0_rvalid_r <= p0_gnt_s;
      p1_rvalid_r <= p1_gnt_s;
      if (p0_gnt_s) begin
        p0_rdata_r <= resp_data_s;
        p0_err_r   <= sel_err_s;
      end else begin
        p0_rdata_r <= p0_rdata_r;
        p0_err_r   <= p0_err_r;
      end
      if (p1_gnt_s) begin
        p1_rdata_r <= resp_data_s;
        p1_err_r   <= sel_err_s;
      end else begin
        p1_rdata_r <= p1_rdata_r;
        p1_err_r   <= p1_err_r;
      end
    end
  end

  assign p0_gnt    = p0_gnt_s;
  assign p1_gnt    = p1_gnt_s;
  assign p0_rvalid = p0_rvalid_r;
  assign p1_rvalid = p1_rvalid_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_rdata  = p1_rdata_r;
  assign p0_err    = p0_err_r;
  assign p1_err    = p1_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus constrained-random traffic
// against a byte-array reference model of memory and a consecutive-wait arbitration model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        p0_req, p0_we, p0_unsigned, p0_gnt, p0_rvalid, p0_err;
  logic [15:0] p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic [1:0]  p0_size;
  logic        p1_req, p1_we, p1_unsigned, p1_gnt, p1_rvalid, p1_err;
  logic [15:0] p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic [1:0]  p1_size;
  logic [15:0] dmem_address;
  logic [31:0] dmem_data, dmem_q;
  logic [3:0]  dmem_wren;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_size(p0_size), .p0_unsigned(p0_unsigned), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_size(p1_size), .p1_unsigned(p1_unsigned), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .dmem_address(dmem_address), .dmem_data(dmem_data), .dmem_wren(dmem_wren),
    .dmem_q(dmem_q)
  );

  always #5 i_clk = ~i_clk;

  // Environment memory: 64 words, asynchronous read, byte-enabled write.
  logic [31:0] env_mem [0:63];
  assign dmem_q = env_mem[dmem_address[7:2]];

  // Store into the environment memory on granted write lanes.
  always @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dmem_wren[i]) env_mem[dmem_address[7:2]][8*i +: 8] <= dmem_data[8*i +: 8];
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [0:255];
  bit          m_rv0, m_rv1, m_err, m_boost;
  logic [31:0] m_rdata;
  int          m_wait;
  int          n_checks = 0;
  int          n_errors = 0;

  // Observations captured by tick for directed checks.
  logic        obs_p1_gnt, obs_p1_rvalid, obs_p0_err;
  logic [3:0]  obs_wren;
  logic [31:0] obs_data, obs_p0_rdata, obs_p1_rdata;
  bit          last_g0, last_g1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_p0(input bit rq, input bit we, input logic [15:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input bit uns);
    p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = wd; p0_size = sz; p0_unsigned = uns;
  endtask

  task automatic set_p1(input bit rq, input bit we, input logic [15:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input bit uns);
    p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = wd; p1_size = sz; p1_unsigned = uns;
  endtask

  task automatic idle();
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic model_reset();
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_wait = 0; m_boost = 1'b0;
  endtask

  // One clock cycle: inputs already driven after a falling edge; check, advance model, wait.
  task automatic tick();
    bit          e0g, e1g, we, uns, er;
    logic [15:0] a;
    logic [1:0]  sz;
    logic [31:0] wd, exp_data, val;
    logic [3:0]  exp_wren;
    int          nb, lo;
    #1;
    e1g = p1_req && (!p0_req || m_boost);
    e0g = p0_req && !e1g;
    check("p0_gnt", p0_gnt, e0g);
    check("p1_gnt", p1_gnt, e1g);
    check("p0_rvalid", p0_rvalid, m_rv0);
    check("p1_rvalid", p1_rvalid, m_rv1);
    if (m_rv0) begin
      check("p0_rdata", p0_rdata, m_rdata);
      check("p0_err", p0_err, m_err);
    end
    if (m_rv1) begin
      check("p1_rdata", p1_rdata, m_rdata);
      check("p1_err", p1_err, m_err);
    end
    obs_p1_gnt = p1_gnt; obs_wren = dmem_wren; obs_data = dmem_data;
    obs_p0_rdata = p0_rdata; obs_p0_err = p0_err;
    obs_p1_rdata = p1_rdata; obs_p1_rvalid = p1_rvalid;
    if (e0g || e1g) begin
      if (e1g) begin
        we = p1_we; a = p1_addr; wd = p1_wdata; sz = p1_size; uns = p1_unsigned;
      end else begin
        we = p0_we; a = p0_addr; wd = p0_wdata; sz = p0_size; uns = p0_unsigned;
      end
      nb = 1 << sz;
      lo = int'(a[1:0]);
      er = (sz == 2'd3) || ((int'(a) % nb) != 0);
      check("dmem_address", dmem_address, a & 16'hFFFC);
      if (we && !er) begin
        exp_wren = 4'b0000;
        exp_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (i >= lo && i < lo + nb) exp_wren[i] = 1'b1;
          exp_data[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        check("dmem_wren", dmem_wren, exp_wren);
        check("dmem_data", dmem_data, exp_data);
      end else begin
        check("dmem_wren", dmem_wren, 4'b0000);
      end
      val = 32'h0;
      if (!we && !er) begin
        for (int k = 0; k < nb; k++) val = val | (32'(ref_mem[int'(a) + k]) << (8*k));
        if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8*nb)) - 32'h1);
      end
      if (we && !er) begin
        for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
      end
      m_rdata = val;
      m_err = er;
    end else begin
      check("idle_address", dmem_address, 16'h0000);
      check("idle_data", dmem_data, 32'h0);
      check("idle_wren", dmem_wren, 4'b0000);
    end
    m_rv0 = e0g;
    m_rv1 = e1g;
    if (e1g) begin
      m_wait = 0; m_boost = 1'b0;
    end else if (p1_req) begin
      m_wait++;
    end else begin
      m_wait = 0;
    end
    if (m_wait >= MAX_WAIT) m_boost = 1'b1;
    last_g0 = e0g;
    last_g1 = e1g;
    @(negedge i_clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) env_mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    model_reset();
    i_reset = 1'b0;
    set_p0(1'b1, 1'b1, 16'h0010, 32'h1, 2'd2, 1'b0);
    set_p1(1'b1, 1'b0, 16'h0020, 32'h0, 2'd2, 1'b0);
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_p0_gnt", p0_gnt, 1'b0);
    check("rst_p1_gnt", p1_gnt, 1'b0);
    check("rst_wren", dmem_wren, 4'b0000);
    check("rst_address", dmem_address, 16'h0000);
    check("rst_data", dmem_data, 32'h0);
    check("rst_p0_rvalid", p0_rvalid, 1'b0);
    check("rst_p1_rvalid", p1_rvalid, 1'b0);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b1;
    idle();

    // Word write then unsigned byte read of the top byte through port 1.
    set_p0(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 2'd2, 1'b0); tick();
    check("r19_wren", obs_wren, 4'hF);
    idle(); set_p1(1'b1, 1'b0, 16'h0013, 32'h0, 2'd0, 1'b1); tick();
    check("r19_p1_gnt", obs_p1_gnt, 1'b1);
    idle(); tick();
    check("r19_p1_rvalid", obs_p1_rvalid, 1'b1);
    check("r19_p1_rdata", obs_p1_rdata, 32'h000000DE);
    tick();
    check("r19_rvalid_drop", obs_p1_rvalid, 1'b0);

    // Upper half write and signed readback.
    set_p0(1'b1, 1'b1, 16'h0022, 32'h00008001, 2'd1, 1'b0); tick();
    check("r20_wren", obs_wren, 4'hC);
    check("r20_data", obs_data, 32'h80018001);
    set_p0(1'b1, 1'b0, 16'h0022, 32'h0, 2'd1, 1'b0); tick();
    idle(); tick();
    check("r20_rdata", obs_p0_rdata, 32'hFFFF8001);

    // Misaligned word read, illegal-size write, then memory unchanged.
    set_p0(1'b1, 1'b0, 16'h0006, 32'h0, 2'd2, 1'b0); tick();
    check("r22_mis_wren", obs_wren, 4'h0);
    set_p0(1'b1, 1'b1, 16'h0020, 32'hFFFFFFFF, 2'd3, 1'b0); tick();
    check("r22_mis_err", obs_p0_err, 1'b1);
    check("r22_mis_rdata", obs_p0_rdata, 32'h0);
    check("r22_ill_wren", obs_wren, 4'h0);
    set_p0(1'b1, 1'b0, 16'h0020, 32'h0, 2'd2, 1'b0); tick();
    check("r22_ill_err", obs_p0_err, 1'b1);
    idle(); tick();
    check("r22_unchanged", obs_p0_rdata, 32'h80010000);

    // Write then immediate read of the same word from the other port.
    set_p0(1'b1, 1'b1, 16'h0040, 32'h12345678, 2'd2, 1'b0); tick();
    idle(); set_p1(1'b1, 1'b0, 16'h0040, 32'h0, 2'd2, 1'b0); tick();
    idle(); tick();
    check("r24_p1_rdata", obs_p1_rdata, 32'h12345678);

    // Both ports requesting continuously: port 1 wins on cycles 5 and 10.
    set_p0(1'b1, 1'b0, 16'h0010, 32'h0, 2'd2, 1'b0);
    set_p1(1'b1, 1'b0, 16'h0040, 32'h0, 2'd2, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("r21_p1_gnt_c%0d", i), obs_p1_gnt, (i == 5 || i == 10));
    end
    idle(); tick();

    // Reset coinciding with a grant edge, then reset during a response cycle.
    set_p0(1'b1, 1'b0, 16'h0010, 32'h0, 2'd2, 1'b0);
    #1;
    check("r23_pre_gnt", p0_gnt, 1'b1);
    #1 i_reset = 1'b0;
    #1;
    check("r23_gnt_forced", p0_gnt, 1'b0);
    check("r23_addr_forced", dmem_address, 16'h0000);
    check("r23_wren_forced", dmem_wren, 4'b0000);
    @(negedge i_clk);
    check("r23_no_rvalid", p0_rvalid, 1'b0);
    i_reset = 1'b1;
    model_reset();
    tick();
    check("r23_resp_pending", p0_rvalid, 1'b1);
    i_reset = 1'b0;
    #1;
    check("r23_rvalid_cleared", p0_rvalid, 1'b0);
    check("r23_rdata_cleared", p0_rdata, 32'h0);
    idle();
    @(negedge i_clk);
    i_reset = 1'b1;
    model_reset();
    set_p1(1'b1, 1'b0, 16'h0013, 32'h0, 2'd0, 1'b1); tick();
    idle(); tick();
    check("r23_after_rdata", obs_p1_rdata, 32'h000000DE);

    // Constrained-random traffic; a denied request holds its fields.
    last_g0 = 1'b1; last_g1 = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!p0_req || last_g0) begin
        set_p0($urandom_range(0, 99) < 65, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
               $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) p0_addr = p0_addr & 16'hFFFC;
      end
      if (!p1_req || last_g1) begin
        set_p1($urandom_range(0, 99) < 50, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
               $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) p1_addr = p1_addr & 16'hFFFC;
      end
      tick();
    end
    idle(); tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
